// File: rtl/minrv32_mem_slave.sv
// minrv32_mem_slave: word-addressed RAM slave for the minrv32 native memory
// bus. It inserts a fixed number of wait states before each one-cycle
// mem_ready pulse, flags out-of-range accesses with bus_err, and keeps a
// saturating count of completed instruction fetches.
module minrv32_mem_slave #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [15:0] fetch_count
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] fetch_q, fetch_d;

  logic [31:0]           ram [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  out_of_range;
  logic                  ram_we;
  logic                  unused_addr_bits;

  // Byte offset within a word has no meaning for this word-only slave.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign word_idx     = addr_q[DEPTH_LOG2+1:2];
  assign out_of_range = |addr_q[31:DEPTH_LOG2+2];

  // Next-state, request capture and response generation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    fetch_d = fetch_q;
    ram_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr[31:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // A withdrawn request is dropped silently; nothing has been committed.
        if (!mem_valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = RESP;
        end
      end
      RESP: begin
        // The response is registered here, so it shows up in the cycle after
        // RESP; the RAM write lands on the same edge, so rdata is pre-write.
        state_d = IDLE;
        ready_d = 1'b1;
        err_d   = out_of_range;
        rdata_d = out_of_range ? 32'h0 : ram[word_idx];
        ram_we  = !out_of_range && (wstrb_q != 4'b0);
        if (instr_q && (wstrb_q == 4'b0) && (fetch_q != 16'hFFFF)) begin
          fetch_d = fetch_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Synchronous reset overrides everything, including a pending write.
    if (!resetn) begin
      state_d = IDLE;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = 32'h0;
      fetch_d = 16'h0;
      ram_we  = 1'b0;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    state_q <= state_d;
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    instr_q <= instr_d;
    ready_q <= ready_d;
    err_q   <= err_d;
    rdata_q <= rdata_d;
    fetch_q <= fetch_d;
  end

  // Byte-lane RAM write at the edge that ends RESP.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; its contents survive resetn and it maps onto
    // plain memory macros.
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) ram[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign bus_err     = err_q;
  assign fetch_count = fetch_q;

endmodule

// File: tb/tb_minrv32_mem_slave.sv
// Bench for minrv32_mem_slave: directed vector table, hand-written abort and
// reset sequences, a zero-wait-state back-to-back check, then randomized
// traffic against a word-array reference model.
module tb_minrv32_mem_slave;

  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, ready1;
  logic [31:0] mem_rdata, rdata1;
  logic        bus_err, err1;
  logic [15:0] fetch_count, fetch1;

  always #5 clk = ~clk;

  minrv32_mem_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .fetch_count(fetch_count)
  );

  // Zero-wait-state build sharing the same bus inputs.
  minrv32_mem_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0w (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(ready1), .mem_rdata(rdata1), .bus_err(err1),
    .fetch_count(fetch1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  // Reference model: RAM as an array of words indexed by address/4.
  logic [31:0] model_mem [int];
  int          model_fetch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the WAITS build, with optional input scrambling
  // after the request has been sampled.
  task automatic run(input string name, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic ins, input bit scr,
                     input bit chk_rd, input logic [31:0] exp_rd, input logic exp_er);
    int          lat;
    logic [31:0] rd;
    logic        er;
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = ins;
    tick();
    if (scr) begin
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
      mem_instr = 1'($urandom);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mem_ready) begin
        lat = k;
        rd  = mem_rdata;
        er  = bus_err;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_instr = 1'b0;
    check({name, "_latency"}, lat, WAITS + 1);
    if (chk_rd) check({name, "_rdata"}, rd, exp_rd);
    check({name, "_bus_err"}, er, exp_er);
    tick();
    check({name, "_ready_single_cycle"}, mem_ready, 1'b0);
  endtask

  function automatic void model_write(int idx, logic [31:0] wd, logic [3:0] ws);
    logic [31:0] w;
    w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
    model_mem[idx] = w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  ws;
    logic        ins, oor;
    int          idx;

    //            addr          wdata         wstrb  instr chk   exp_rd        err
    vecs[0]  = '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{32'h0000_0010, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h0000_0020, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{32'h0000_0020, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 32'h11223344, 1'b0};
    vecs[4]  = '{32'h0000_0020, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{32'h0000_1000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[7]  = '{32'h0000_1000, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[8]  = '{32'h0000_0000, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{32'h0000_0013, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[11] = '{32'h0000_0FFC, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{32'h0000_0FFF, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0};
    vecs[13] = '{32'h0000_0008, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};

    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    repeat (3) tick();
    check("reset_ready", mem_ready, 1'b0);
    check("reset_bus_err", bus_err, 1'b0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_fetch_count", fetch_count, 16'h0);
    check("reset_ready_w0", ready1, 1'b0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
          vecs[i].instr, 1'b0, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Request withdrawn after one wait cycle: no response, no write.
    mem_valid = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h12345678; mem_wstrb = 4'hF;
    tick();
    tick();
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_ready", mem_ready, 1'b0);
    end
    check("abort_no_bus_err", bus_err, 1'b0);
    run("after_abort_read", 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 1'b0);

    // Reset during WAIT of an instruction fetch.
    mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("rst_wait_ready", mem_ready, 1'b0);
    check("rst_wait_rdata", mem_rdata, 32'h0);
    check("rst_wait_fetch", fetch_count, 16'h0);
    resetn = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_wait_no_ready", mem_ready, 1'b0);
    end
    model_fetch = 0;
    for (int k = 0; k < 3; k++) begin
      run("fetch", 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      model_fetch++;
    end
    check("fetch_count_three", fetch_count, 16'd3);

    // Reset in RESP of a write: the write must not land.
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h99999999; mem_wstrb = 4'hF;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("rst_resp_no_ready", mem_ready, 1'b0);
    resetn = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'h0;
    tick();
    tick();
    run("rst_resp_read", 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h11BB33DD, 1'b0);
    model_fetch = 0;

    // Held request: zero-wait build responds every other cycle, the
    // two-wait build every fourth.
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0; mem_instr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("w0_ready_c%0d", k), ready1, 1'((k % 2) == 0));
      check($sformatf("w2_held_ready_c%0d", k), mem_ready, 1'((k % 4) == 0));
      if (ready1) check($sformatf("w0_rdata_c%0d", k), rdata1, 32'hDEADBEEF);
    end
    mem_valid = 1'b0;
    tick();
    tick();

    // Randomized traffic on eight words, scrambling inputs after sampling.
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      run("rand_init", 32'h100 + 32'(4 * i), wd, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      model_write(64 + i, wd, 4'hF);
    end
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a + 32'h1000;
      end else begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      end
      ws  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      ins = 1'($urandom_range(0, 1));
      wd  = $urandom;
      oor = (a >= 32'h1000);
      idx = int'(a / 4);
      exp_rd = oor ? 32'h0 : model_mem[idx];
      run("rand", a, wd, ws, ins, 1'b1, 1'b1, exp_rd, oor);
      if (!oor && ws != 4'h0) model_write(idx, wd, ws);
      if (ins && ws == 4'h0 && model_fetch < 65535) model_fetch++;
      check("rand_fetch_count", fetch_count, 32'(model_fetch));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/minrv32_mem_slave.md
MINRV32_MEM_SLAVE -- requirements
Module: minrv32_mem_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set word-addressed RAM depth to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal 0..15, SHALL set wait states inserted before mem_ready.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port resetn  input  1  reset, synchronous, active-low.
REQ-005 Port mem_valid  input  1  core request active.
REQ-006 Port mem_instr  input  1  request is an instruction fetch.
REQ-007 Port mem_addr  input  32  byte address, word-aligned use only.
REQ-008 Port mem_wdata  input  32  write data.
REQ-009 Port mem_wstrb  input  4  byte-lane write enables; 0 means read.
REQ-010 Port mem_ready  output  1  one-cycle completion pulse.
REQ-011 Port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-012 Port bus_err  output  1  pulses with mem_ready on out-of-range access.
REQ-013 Port fetch_count  output  16  saturating count of completed instruction fetches.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE with mem_valid=1 at a clock edge SHALL latch addr/wdata/wstrb/instr, load wait counter with WAIT_CYCLES, and go to WAIT, or to RESP directly if WAIT_CYCLES=0.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 1 (or 0 on entry).
REQ-017 Latency: request first sampled in IDLE at edge t SHALL give mem_ready=1 during exactly the cycle after edge t+WAIT_CYCLES+1 (i.e. WAIT_CYCLES+1 cycles after sampling).
REQ-018 mem_ready SHALL be registered, high only in RESP, never two consecutive cycles.
REQ-019 RESP SHALL always go to IDLE; a request held or reasserted in the following IDLE cycle SHALL be accepted normally (minimum 1-cycle bubble between transactions).
REQ-020 Word index SHALL be mem_addr[DEPTH_LOG2+1:2]; mem_addr[1:0] ignored.
REQ-021 Out-of-range (mem_addr[31:DEPTH_LOG2+2] nonzero) SHALL assert bus_err with mem_ready, return mem_rdata=0, suppress any write.
REQ-022 Read (wstrb=0) SHALL present RAM word at RESP; mem_rdata SHALL hold its last value outside RESP.
REQ-023 Write SHALL update only lanes with wstrb[i]=1 (lane i = bits 8i+7:8i) at the edge ending RESP; mem_rdata during a write SHALL be the pre-write word.
REQ-024 If mem_valid drops during WAIT, the FSM SHALL return to IDLE without mem_ready, without bus_err, without write.
REQ-025 fetch_count SHALL increment on each RESP with latched instr=1 and wstrb=0, saturating at 16'hFFFF.
REQ-026 Input changes during WAIT/RESP other than mem_valid SHALL be ignored (latched values used).

Reset
REQ-027 resetn=0 at an edge SHALL force IDLE, mem_ready=0, bus_err=0, mem_rdata=0, fetch_count=0.
REQ-028 Reset mid-transaction SHALL abort it with no RAM write and no mem_ready pulse.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-030 Write 0xDEADBEEF, wstrb=4'hF, addr 0x10, then read 0x10 -> rdata 0xDEADBEEF, ready exactly 3 cycles after each sampling (WAIT_CYCLES=2).
REQ-031 Prior 0x11223344 at 0x20, write 0xAABBCCDD wstrb=4'b0101, read -> 0x11BB33DD.
REQ-032 Read addr 0x0000_1000 (DEPTH_LOG2=10) -> ready+bus_err same cycle, rdata 0; write there leaves address 0x0 unchanged.
REQ-033 mem_valid dropped after 1 WAIT cycle on a write to 0x8 -> no ready, word at 0x8 unchanged; next request completes normally.
REQ-034 resetn=0 during WAIT of instr fetch -> no ready, fetch_count stays 0; three subsequent fetches -> fetch_count=3.
REQ-035 WAIT_CYCLES=0 build, back-to-back reads with mem_valid held high -> ready every other cycle, 1-cycle latency.
